// File: rtl/spi_shift_engine.sv
// SPI master shift/transfer engine: serialises one word on MOSI, captures MISO,
// drives slave select and SCK gating from externally generated sample/shift strobes.
module spi_shift_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_clk,
  input  logic                  shift_clk,
  input  logic [2:0]            spicr,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  ss_n,
  output logic                  sck_en,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  done,
  output logic                  overrun
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cnt_inc;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  mosi_q, mosi_d;
  logic                  ss_n_q, ss_n_d;
  logic                  sck_en_q, sck_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic                  lsbfe;
  logic [DATA_WIDTH-1:0] tx_adv;

  assign lsbfe = spicr[2];

  // The bit currently on the wire sits at the end of the shifter nearest MOSI.
  function automatic logic wire_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] w,
                                                     input logic lsb);
    return lsb ? {1'b0, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b, input logic lsb);
    return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  // Next-state logic: sample is applied before the shift decision in the same cycle.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q;
    rx_data_d = rx_data_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    tx_adv    = tx_shift(tx_q, lsbfe);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_d      = tx_data;
          rx_d      = '0;
          cnt_d     = '0;
          overrun_d = 1'b0;
          mosi_d    = wire_bit(tx_data, lsbfe);
          state_d   = ST_LEAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEAD: begin
        // Lead strobe only opens the SCK window; the first bit is already on MOSI.
        if (shift_clk) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_LEAD;
        end
      end
      ST_XFER: begin
        if (sample_clk && (cnt_q != CNT_FULL)) begin
          rx_d    = rx_shift(rx_q, miso, lsbfe);
          cnt_inc = cnt_q + CNT_ONE;
        end else begin
          cnt_inc = cnt_q;
        end
        cnt_d = cnt_inc;
        if (shift_clk) begin
          if (cnt_inc == CNT_FULL) begin
            state_d = ST_TRAIL;
          end else if (cnt_inc != '0) begin
            tx_d   = tx_adv;
            mosi_d = wire_bit(tx_adv, lsbfe);
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_TRAIL: begin
        if (shift_clk) begin
          state_d   = ST_IDLE;
          rx_data_d = rx_q;
          done_d    = 1'b1;
        end else begin
          state_d = ST_TRAIL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end

    busy_d   = (state_d != ST_IDLE);
    ss_n_d   = (state_d == ST_IDLE);
    sck_en_d = (state_d == ST_XFER);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      rx_data_q <= '0;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      sck_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      rx_data_q <= rx_data_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      sck_en_q  <= sck_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;
  assign sck_en  = sck_en_q;
  assign busy    = busy_q;
  assign rx_data = rx_data_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine (DATA_WIDTH=8): MSB/LSB-first transfers,
// overrun, back-to-back starts, mid-transfer reset and stray strobes.
module tb_spi_shift_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_clk;
  logic       shift_clk;
  logic [2:0] spicr;
  logic       start;
  logic [7:0] tx_data;
  logic       miso;
  logic       mosi;
  logic       ss_n;
  logic       sck_en;
  logic       busy;
  logic [7:0] rx_data;
  logic       done;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int ss_shifts = 0;
  int d0;
  int s0;

  spi_shift_engine #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .sample_clk(sample_clk), .shift_clk(shift_clk),
    .spicr(spicr), .start(start), .tx_data(tx_data), .miso(miso), .mosi(mosi),
    .ss_n(ss_n), .sck_en(sck_en), .busy(busy), .rx_data(rx_data), .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Inputs are stable around negedge, so this sees what the next posedge will use.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (shift_clk === 1'b1 && ss_n === 1'b0) ss_shifts++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic sh, input logic sa);
    shift_clk = sh;
    sample_clk = sa;
    cyc();
    shift_clk = 1'b0;
    sample_clk = 1'b0;
    cyc();
  endtask

  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] slave, input logic lsb,
                          input logic hold, input int ovr_at, input logic stray);
    logic [7:0] seen;
    int idx;
    seen = 8'h00;
    spicr = {lsb, 2'b00};
    tx_data = tx;
    start = 1'b1;
    cyc();
    start = hold;
    chk("acc_ss_n", 32'(ss_n), 32'd0);
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_mosi", 32'(mosi), 32'(lsb ? tx[0] : tx[7]));
    chk("acc_overrun", 32'(overrun), 32'd0);
    if (stray) begin
      miso = 1'b1;
      pulse(1'b0, 1'b1);
    end
    pulse(1'b1, 1'b0);
    chk("lead_sck_en", 32'(sck_en), 32'd1);
    for (int i = 0; i < 8; i++) begin
      idx = lsb ? i : 7 - i;
      miso = slave[idx];
      seen[idx] = mosi;
      if (i == ovr_at) begin
        start = 1'b1;
        tx_data = 8'hFF;
      end
      pulse(1'b0, 1'b1);
      if (i == ovr_at) begin
        start = hold;
        tx_data = tx;
      end
      if (i == 7 && stray) begin
        miso = ~miso;
        pulse(1'b0, 1'b1);
      end
      pulse(1'b1, 1'b0);
    end
    chk("mosi_seq", 32'(seen), 32'(tx));
    chk("trail_sck_en", 32'(sck_en), 32'd0);
    chk("trail_ss_n", 32'(ss_n), 32'd0);
    if (stray) pulse(1'b0, 1'b1);
    shift_clk = 1'b1;
    cyc();
    shift_clk = 1'b0;
    chk("end_done", 32'(done), 32'd1);
    chk("end_ss_n", 32'(ss_n), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_rx_data", 32'(rx_data), 32'(slave));
  endtask

  initial begin
    reset = 1'b0;
    sample_clk = 1'b0;
    shift_clk = 1'b0;
    spicr = 3'b000;
    start = 1'b0;
    tx_data = 8'h00;
    miso = 1'b0;
    cyc();
    cyc();
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_ss_n", 32'(ss_n), 32'd1);
    chk("rst_sck_en", 32'(sck_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    cyc();

    // MSB first, 0xA5 out, slave returns 0x3C
    d0 = done_cnt;
    s0 = ss_shifts;
    run_xfer(8'hA5, 8'h3C, 1'b0, 1'b0, -1, 1'b0);
    cyc();
    chk("msb_done_low", 32'(done), 32'd0);
    chk("msb_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("msb_ss_low_shifts", 32'(ss_shifts - s0), 32'd10);
    chk("msb_overrun", 32'(overrun), 32'd0);

    // LSB first
    run_xfer(8'hA5, 8'h3C, 1'b1, 1'b0, -1, 1'b0);
    cyc();

    // Overrun: extra start with 0xFF after the 4th sample
    run_xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 3, 1'b0);
    cyc();
    cyc();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("ovr_rx_hold", 32'(rx_data), 32'h3C);

    // Stray sample strobes in IDLE, LEAD, at full count and in TRAIL; also clears overrun
    miso = 1'b1;
    pulse(1'b0, 1'b1);
    chk("idle_stray_busy", 32'(busy), 32'd0);
    chk("idle_stray_rx", 32'(rx_data), 32'h3C);
    d0 = done_cnt;
    s0 = ss_shifts;
    run_xfer(8'hC6, 8'h71, 1'b0, 1'b0, -1, 1'b1);
    cyc();
    chk("stray_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("stray_ss_low_shifts", 32'(ss_shifts - s0), 32'd10);

    // Back-to-back with start held high
    d0 = done_cnt;
    run_xfer(8'h12, 8'h81, 1'b0, 1'b1, -1, 1'b0);
    tx_data = 8'h34;
    run_xfer(8'h34, 8'h6E, 1'b0, 1'b1, -1, 1'b0);
    start = 1'b0;
    cyc();
    chk("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);
    chk("b2b_idle", 32'(busy), 32'd0);
    chk("b2b_rx_data", 32'(rx_data), 32'h6E);

    // Reset after 4 samples
    spicr = 3'b000;
    tx_data = 8'hC3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      miso = 1'b1;
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
    end
    chk("pre_rst_busy", 32'(busy), 32'd1);
    d0 = done_cnt;
    reset = 1'b0;
    #2;
    chk("mid_rst_ss_n", 32'(ss_n), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    cyc();
    chk("mid_rst_mosi", 32'(mosi), 32'd0);
    chk("mid_rst_sck_en", 32'(sck_en), 32'd0);
    chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    cyc();
    cyc();
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    run_xfer(8'h5A, 8'h96, 1'b0, 1'b0, -1, 1'b0);
    cyc();
    chk("post_rst_done_pulses", 32'(done_cnt - d0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
